seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU. Registered single-cycle logic/add/compare ops plus iterative
//  unsigned multiply (shift-add) and divide (restoring), behind a start/busy/done handshake.
//  Sits in the EX stage of the multi-cycle datapath. The controller asserts start and stalls
//  while busy=1. Op encoding of the existing 3-bit control field is retained and extended.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=4)
//  CNT_W   $clog2(WIDTH)+1  iteration counter width (derived, not overridden)
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        launch op; sampled only when busy=0
//  alu_ctrl    in   3        op: 0 AND,1 OR,2 ADD,3 MULU,4 DIVU,5 SLTU,6 SUB,7 SLT(signed)
//  a, b        in   WIDTH    operands (latched on accepted start)
//  result      out  WIDTH    primary result (MULU: low half, DIVU: quotient)
//  result_hi   out  WIDTH    MULU: high half; DIVU: remainder; others: 0
//  zero        out  1        result == 0 (registered with result)
//  busy        out  1        op in progress; start ignored while high
//  done        out  1        one-cycle pulse when result/result_hi/zero become valid
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; result, result_hi, zero, busy, done, counter, operands
//    all 0. Reset mid-operation aborts it; no done pulse is produced for the aborted op.
//  - FSM: IDLE -> (start & single-cycle op) -> IDLE with done; IDLE -> (start & MULU) -> MUL;
//    IDLE -> (start & DIVU & b!=0) -> DIV; MUL/DIV -> IDLE when counter reaches WIDTH.
//  - Single-cycle ops (0,1,2,5,6,7): start in cycle N -> result valid and done=1 in cycle N+1.
//    busy stays 0. Back-to-back starts every cycle are legal.
//  - ADD/SUB: modulo 2^WIDTH, carry discarded. SLT: signed compare, result 1 or 0.
//    SLTU: unsigned compare, result 1 or 0. Other op codes do not occur (all 8 are defined).
//  - MULU/DIVU: busy=1 from cycle N+1 through N+WIDTH; done=1 and busy=0 in cycle N+WIDTH+1.
//    The product is the full 2*WIDTH bits, split into {result_hi,result}.
//  - DIVU with b==0: single-cycle path. result = all ones, result_hi = a, done in N+1.
//  - Starts while busy=1 are ignored (not queued). Operands and op are latched on acceptance;
//    later changes to a/b/alu_ctrl do not affect an op in flight.
//  - done is high for exactly one cycle per accepted op. Outputs hold their last value until the
//    next op completes; intermediate iteration values never appear on result/result_hi.
//  - zero reflects result only (not result_hi). It updates in the same cycle as done.
// CONFIGURATION
//  ALU_OVF_EN defined: adds output port ovf (1 bit), registered with done.
//    ovf=1 when ADD or SUB causes signed overflow. For MULU, ovf=1 when result_hi!=0.
//    ovf=0 for every other op. ovf resets to 0.
//  ALU_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour is identical.
// TESTING (WIDTH=32)
//  1. Reset then idle: all outputs 0, busy=0. Assert rst_n=0 mid-MULU -> busy/done 0 at once,
//     and no done after release.
//  2. ADD a=0x7FFFFFFF b=1 -> result=0x80000000, done next cycle, zero=0
//     (ovf=1 with ALU_OVF_EN). SUB 5-5 -> result=0, zero=1.
//  3. SLT a=0xFFFFFFFF b=1 -> 1. SLTU with the same operands -> 0. Issue both back-to-back
//     -> two consecutive done pulses.
//  4. MULU a=0xFFFFFFFF b=2 -> result=0xFFFFFFFE, result_hi=1; done exactly 33 cycles after
//     start; busy high 32 cycles. A second start mid-op is ignored.
//  5. DIVU a=100 b=7 -> result=14, result_hi=2 after 33 cycles. DIVU a=9 b=0 -> result=0xFFFFFFFF,
//     result_hi=9, done next cycle.
//  6. Change a/b during a MULU (3*4) -> result=12 unaffected. Rerun all checks with WIDTH=8
//     and random operands against a reference model.

Source files
------------

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: registered single-cycle ops plus iterative MULU/DIVU.
// Optional ALU_OVF_EN adds a registered signed-overflow / MULU-high-nonzero flag on port ovf.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             busy,
    output logic             done
`ifdef ALU_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_MULU = 3'd3;
    localparam logic [2:0] OP_DIVU = 3'd4;
    localparam logic [2:0] OP_SLTU = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_SLT  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sum, diff, sc_res;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] mul_acc_n, mul_lo_n, div_acc_n, div_lo_n;

    assign sum  = a + b;
    assign diff = a - b;

    // Shift-add: {acc,lo} holds the partial product, lo starts as the multiplier.
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc_n = mul_sum[WIDTH:1];
    assign mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring divide: acc is the partial remainder, lo shifts dividend out and quotient in.
    assign div_shift = {acc_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_acc_n = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign div_lo_n  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};

    always_comb begin
        sc_res = '0;
        case (alu_ctrl)
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_ADD:  sc_res = sum;
            OP_SUB:  sc_res = diff;
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (alu_ctrl == OP_MULU) begin
                        state_d = S_MUL;
                        opnd_d  = a;
                        lo_d    = b;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else if (alu_ctrl == OP_DIVU && b != '0) begin
                        state_d = S_DIV;
                        opnd_d  = b;
                        lo_d    = a;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else if (alu_ctrl == OP_DIVU) begin
                        result_d    = '1;
                        result_hi_d = a;
                        zero_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        result_d    = sc_res;
                        result_hi_d = '0;
                        zero_d      = (sc_res == '0);
                        done_d      = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc_n;
                lo_d  = mul_lo_n;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == LAST) begin
                    state_d     = S_IDLE;
                    result_d    = mul_lo_n;
                    result_hi_d = mul_acc_n;
                    zero_d      = (mul_lo_n == '0);
                    done_d      = 1'b1;
                end
            end
            S_DIV: begin
                acc_d = div_acc_n;
                lo_d  = div_lo_n;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == LAST) begin
                    state_d     = S_IDLE;
                    result_d    = div_lo_n;
                    result_hi_d = div_acc_n;
                    zero_d      = (div_lo_n == '0);
                    done_d      = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            done_q      <= done_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

`ifdef ALU_OVF_EN
    logic ovf_q, ovf_d, sc_ovf;

    assign sc_ovf = (alu_ctrl == OP_ADD) ? ((a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1])) :
                    (alu_ctrl == OP_SUB) ? ((a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])) :
                    1'b0;

    always_comb begin
        ovf_d = ovf_q;
        if (done_d) begin
            if (state_q == S_MUL)       ovf_d = (mul_acc_n != '0);
            else if (state_q == S_IDLE) ovf_d = sc_ovf;
            else                        ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [2:0]  ctrl32 = '0, ctrl8 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [31:0] res32, hi32;
    logic [7:0]  res8, hi8;
    logic        zero32, busy32, done32, zero8, busy8, done8;
`ifdef ALU_OVF_EN
    logic        ovf32, ovf8;
`endif
    int n_cmp = 0;
    int n_bad = 0;
    int lat, bcnt, npulse;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .alu_ctrl(ctrl32), .a(a32), .b(b32),
        .result(res32), .result_hi(hi32), .zero(zero32), .busy(busy32), .done(done32)
`ifdef ALU_OVF_EN
        , .ovf(ovf32)
`endif
    );

    seq_alu #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .alu_ctrl(ctrl8), .a(a8), .b(b8),
        .result(res8), .result_hi(hi8), .zero(zero8), .busy(busy8), .done(done8)
`ifdef ALU_OVF_EN
        , .ovf(ovf8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one start cycle; returns at the negedge of cycle N+1.
    task automatic issue(input bit w8, input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        if (w8) begin
            start8 = 1'b1; ctrl8 = op; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            start32 = 1'b1; ctrl32 = op; a32 = av; b32 = bv;
        end
        @(negedge clk);
        start8 = 1'b0;
        start32 = 1'b0;
    endtask

    // Counts cycles from start until done; optional disturbance injects an ignored start and new operands.
    task automatic wait_done(input bit w8, input bit disturb, output int l, output int bc);
        l = 1;
        bc = 0;
        while (!(w8 ? done8 : done32) && l < 100) begin
            if (w8 ? busy8 : busy32) bc++;
            if (disturb && l == 4) begin
                start32 = 1'b1; ctrl32 = 3'd2; a32 = 32'h11; b32 = 32'h22;
                start8  = 1'b1; ctrl8  = 3'd2; a8  = 8'h11;  b8  = 8'h22;
            end else begin
                start32 = 1'b0;
                start8  = 1'b0;
            end
            @(negedge clk);
            l++;
        end
        start32 = 1'b0;
        start8  = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_result", res32, 0);
        check("rst_result_hi", hi32, 0);
        check("rst_zero", zero32, 0);
        check("rst_busy", busy32, 0);
        check("rst_done", done32, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy32, 0);
        check("idle_done", done32, 0);

        issue(0, 3'd2, 32'h7FFF_FFFF, 32'h1);
        check("add_done", done32, 1);
        check("add_busy", busy32, 0);
        check("add_result", res32, 32'h8000_0000);
        check("add_zero", zero32, 0);
        check("add_hi", hi32, 0);
`ifdef ALU_OVF_EN
        check("add_ovf", ovf32, 1);
`endif
        issue(0, 3'd6, 32'd5, 32'd5);
        check("sub_result", res32, 0);
        check("sub_zero", zero32, 1);
`ifdef ALU_OVF_EN
        check("sub_ovf", ovf32, 0);
`endif
        issue(0, 3'd6, 32'd3, 32'd5);
        check("sub_neg", res32, 32'hFFFF_FFFE);
        issue(0, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and_result", res32, 32'hF000_F000);
        issue(0, 3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("or_result", res32, 32'hFFF0_FFF0);

        // SLT then SLTU in consecutive cycles
        @(negedge clk);
        start32 = 1'b1; ctrl32 = 3'd7; a32 = 32'hFFFF_FFFF; b32 = 32'h1;
        @(negedge clk);
        ctrl32 = 3'd5;
        check("slt_done", done32, 1);
        check("slt_result", res32, 1);
        @(negedge clk);
        start32 = 1'b0;
        check("sltu_done", done32, 1);
        check("sltu_result", res32, 0);
        check("sltu_zero", zero32, 1);
        @(negedge clk);
        check("sltu_done_clear", done32, 0);

        issue(0, 3'd3, 32'hFFFF_FFFF, 32'd2);
        wait_done(0, 1, lat, bcnt);
        check("mulu_latency", lat, 33);
        check("mulu_busy_cycles", bcnt, 32);
        check("mulu_busy_at_done", busy32, 0);
        check("mulu_lo", res32, 32'hFFFF_FFFE);
        check("mulu_hi", hi32, 32'h1);
`ifdef ALU_OVF_EN
        check("mulu_ovf", ovf32, 1);
`endif
        @(negedge clk);
        check("mulu_done_pulse", done32, 0);
        check("mulu_hold", res32, 32'hFFFF_FFFE);

        issue(0, 3'd4, 32'd100, 32'd7);
        wait_done(0, 0, lat, bcnt);
        check("divu_latency", lat, 33);
        check("divu_quot", res32, 32'd14);
        check("divu_rem", hi32, 32'd2);
        issue(0, 3'd4, 32'd3, 32'd7);
        wait_done(0, 0, lat, bcnt);
        check("divu_small_quot", res32, 0);
        check("divu_small_rem", hi32, 32'd3);
        check("divu_small_zero", zero32, 1);
        issue(0, 3'd4, 32'd9, 32'd0);
        check("div0_done", done32, 1);
        check("div0_busy", busy32, 0);
        check("div0_quot", res32, 32'hFFFF_FFFF);
        check("div0_rem", hi32, 32'd9);

        issue(0, 3'd3, 32'd3, 32'd4);
        wait_done(0, 1, lat, bcnt);
        check("mul_latched_lo", res32, 32'd12);
        check("mul_latched_hi", hi32, 0);

        issue(1, 3'd3, 32'hFF, 32'hFF);
        wait_done(1, 1, lat, bcnt);
        check("w8_mulu_latency", lat, 9);
        check("w8_mulu_busy", bcnt, 8);
        check("w8_mulu_lo", res8, 8'h01);
        check("w8_mulu_hi", hi8, 8'hFE);
        issue(1, 3'd4, 32'd200, 32'd9);
        wait_done(1, 0, lat, bcnt);
        check("w8_divu_quot", res8, 8'd22);
        check("w8_divu_rem", hi8, 8'd2);
        issue(1, 3'd7, 32'h80, 32'h7F);
        check("w8_slt", res8, 8'd1);
        issue(1, 3'd5, 32'h80, 32'h7F);
        check("w8_sltu", res8, 8'd0);
        issue(1, 3'd2, 32'hFF, 32'h01);
        check("w8_add_wrap", res8, 8'd0);
        check("w8_add_zero", zero8, 1);

        issue(0, 3'd3, 32'd7, 32'd9);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy32, 0);
        check("abort_done", done32, 0);
        check("abort_result", res32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done32) npulse++;
        end
        check("abort_no_done", npulse, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
